aes128_job_sched: RTL and testbench

- Shares one free-running pipelined aes128 core among NUM_REQ requesters.
- Arbitrates requests round-robin and drives the core's state/key inputs.
- Tracks each in-flight block's requester ID through the core latency.
- Buffers results in an output FIFO with valid/ready backpressure.
- The aes128 core is instantiated beside this block, which connects only to its state, key and out ports.

---
 rtl/aes128_job_sched.sv | 186 ++++++++++++++++++
 tb/tb_aes128_job_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_job_sched.sv
// Round-robin job scheduler that shares one free-running pipelined aes128 core
// among NUM_REQ requesters, tags blocks through the core latency and buffers results.

module aes128_job_sched_chk #(
  parameter int NUM_REQ = 2
) (
  input logic               clk,
  input logic               reset,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               fifo_wr,
  input logic               fifo_full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(fifo_wr && fifo_full))
    else $error("result FIFO written while full");

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready))
    else $error("more than one req_ready bit high");

endmodule

module aes128_job_sched #(
  parameter int NUM_REQ    = 2,
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_state,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic [127:0]           core_state,
  output logic [127:0]           core_key,
  input  logic [127:0]           core_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  logic [127:0]    state_arr_s [NUM_REQ];
  logic [127:0]    key_arr_s   [NUM_REQ];
  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] gnt_idx_s;
  logic [ID_W-1:0] cand_s;
  int              rr_idx_s;
  logic            gnt_found_s;
  logic            hs_s;
  logic            allow_s;
  logic            pop_s;
  logic            wr_s;
  logic            fifo_full_s;
  logic [CW-1:0]   inflight_r;
  logic [CW-1:0]   fifo_cnt_r;
  logic [CW-1:0]   outstanding_s;
  logic [LATENCY:0] tag_vld_r;
  logic [ID_W-1:0] tag_id_r    [0:LATENCY];
  logic [127:0]    fifo_data_r [0:FIFO_DEPTH-1];
  logic [ID_W-1:0] fifo_id_r   [0:FIFO_DEPTH-1];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign state_arr_s[g] = req_state[128*g +: 128];
    assign key_arr_s[g]   = req_key[128*g +: 128];
  end

  // A pop in this cycle returns its credit immediately so issue and pop can coincide.
  assign pop_s         = rsp_valid && rsp_ready;
  assign outstanding_s = inflight_r + fifo_cnt_r - {{(CW-1){1'b0}}, pop_s};
  assign allow_s       = !reset && (outstanding_s < CW'(FIFO_DEPTH));
  assign hs_s          = gnt_found_s;
  assign wr_s          = tag_vld_r[LATENCY];
  assign fifo_full_s   = (fifo_cnt_r == CW'(FIFO_DEPTH));

  assign rsp_valid = (fifo_cnt_r != '0);
  assign rsp_data  = fifo_data_r[rd_ptr_r];
  assign rsp_id    = fifo_id_r[rd_ptr_r];
  assign busy      = (inflight_r != '0) || (fifo_cnt_r != '0);

  // Round-robin grant: first valid requester at or after the pointer, wrapping.
  always_comb begin
    req_ready   = '0;
    gnt_idx_s   = '0;
    gnt_found_s = 1'b0;
    rr_idx_s    = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx_s = int'(ptr_r) + i;
      if (rr_idx_s >= NUM_REQ) begin
        rr_idx_s = rr_idx_s - NUM_REQ;
      end else begin
        rr_idx_s = rr_idx_s;
      end
      cand_s = ID_W'(rr_idx_s);
      if (allow_s && !gnt_found_s && req_valid[cand_s]) begin
        gnt_found_s       = 1'b1;
        gnt_idx_s         = cand_s;
        req_ready[cand_s] = 1'b1;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Pointer and core input registers; core inputs hold when nothing is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r      <= '0;
      core_state <= '0;
      core_key   <= '0;
    end else if (hs_s) begin
      ptr_r      <= (int'(gnt_idx_s) == NUM_REQ - 1) ? '0 : gnt_idx_s + ID_W'(1);
      core_state <= state_arr_s[gnt_idx_s];
      core_key   <= key_arr_s[gnt_idx_s];
    end else begin
      ptr_r      <= ptr_r;
      core_state <= core_state;
      core_key   <= core_key;
    end
  end

  // Tag tracker mirrors the core pipeline and never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_r  <= '0;
      inflight_r <= '0;
      for (int k = 0; k <= LATENCY; k++) begin
        tag_id_r[k] <= '0;
      end
    end else begin
      tag_vld_r   <= {tag_vld_r[LATENCY-1:0], hs_s};
      inflight_r  <= inflight_r + CW'(hs_s) - CW'(wr_s);
      tag_id_r[0] <= gnt_idx_s;
      for (int k = 1; k <= LATENCY; k++) begin
        tag_id_r[k] <= tag_id_r[k-1];
      end
    end
  end

  // Result FIFO: capture on tag exit, pop on rsp handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_data_r[k] <= '0;
        fifo_id_r[k]   <= '0;
      end
    end else begin
      if (wr_s) begin
        fifo_data_r[wr_ptr_r] <= core_out;
        fifo_id_r[wr_ptr_r]   <= tag_id_r[LATENCY];
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      fifo_cnt_r <= fifo_cnt_r + CW'(wr_s) - CW'(pop_s);
    end
  end

  aes128_job_sched_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .req_ready (req_ready),
    .fifo_wr   (wr_s),
    .fifo_full (fifo_full_s)
  );

endmodule

// File: tb/tb_aes128_job_sched.sv
// Scoreboard bench for aes128_job_sched; the core is modelled as a LATENCY-deep
// delay line producing state^key.

module tb_aes128_job_sched;

  localparam int NUM_REQ    = 2;
  localparam int LATENCY    = 21;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = 1;

  logic                   clk;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_state;
  logic [NUM_REQ*128-1:0] req_key;
  logic [127:0]           core_state;
  logic [127:0]           core_key;
  logic [127:0]           core_out;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [127:0]           rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;

  aes128_job_sched #(
    .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .req_key(req_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  // Core stand-in: state^key after LATENCY clock edges.
  logic [127:0] core_pipe [0:LATENCY-1];
  always @(posedge clk) begin
    core_pipe[0] <= core_state ^ core_key;
    for (int k = 1; k < LATENCY; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign core_out = core_pipe[LATENCY-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard and handshake log
  logic [127:0]    sb_data[$];
  logic [ID_W-1:0] sb_id[$];
  int              grant_log[$];
  int              grant_cyc[$];
  int              hs_count = 0;
  int              pops = 0;

  always @(negedge clk) begin
    if (reset) begin
      sb_data.delete();
      sb_id.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb_data.size() == 0) begin
          check_eq("rsp_unexpected", 128'(rsp_valid), 128'd0);
        end else begin
          check_eq("rsp_data", rsp_data, sb_data.pop_front());
          check_eq("rsp_id", 128'(rsp_id), 128'(sb_id.pop_front()));
        end
        pops++;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_data.push_back(req_state[128*i +: 128] ^ req_key[128*i +: 128]);
          sb_id.push_back(ID_W'(i));
          grant_log.push_back(i);
          grant_cyc.push_back(cyc);
          hs_count++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_state[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
      req_key[128*i +: 128]   = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, 128'(busy), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, hs0, pops0, mark, opps, seen;
    logic [127:0] exp_a, exp_b;

    reset = 1'b1; req_valid = 2'b11; req_state = '0; req_key = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_req_ready", 128'(req_ready), 128'd0);
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_core_state", core_state, 128'd0);
    check_eq("rst_core_key", core_key, 128'd0);
    check_eq("rst_rsp_data", rsp_data, 128'd0);
    check_eq("rst_rsp_id", 128'(rsp_id), 128'd0);
    tick(); reset = 1'b0; req_valid = 2'b00;
    tick();

    // Single block: 1^3 from requester 0, response in cycle 23
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b01; req_state[127:0] = 128'h1; req_key[127:0] = 128'h3;
    @(negedge clk);
    check_eq("t1_grant", 128'(req_ready), 128'd1);
    tick(); req_valid = 2'b00;
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      if (lat == 5) check_eq("t1_busy", 128'(busy), 128'd1);
      if (rsp_valid) break;
      tick();
      lat++;
    end
    check_eq("t1_latency", 128'(lat), 128'd23);
    check_eq("t1_data", rsp_data, 128'h2);
    check_eq("t1_id", 128'(rsp_id), 128'd0);
    tick();
    wait_idle("t1_idle");

    // Round-robin with both requesters valid; pointer starts at 1
    grant_log.delete(); grant_cyc.delete();
    tick();
    for (int c = 0; c < 50; c++) begin
      rand_req(); req_valid = 2'b11;
      tick();
    end
    req_valid = 2'b00;
    check_eq("t2_grant_count", 128'(grant_log.size()), 128'd12);
    for (int k = 0; k < grant_log.size(); k++)
      check_eq($sformatf("t2_grant_%0d", k), 128'(grant_log[k]), 128'((k + 1) % 2));
    if (grant_cyc.size() >= 5) begin
      check_eq("t2_b2b", 128'(grant_cyc[3] - grant_cyc[0]), 128'd3);
      check_eq("t2_refill", 128'(grant_cyc[4] - grant_cyc[0]), 128'd23);
    end else begin
      check_eq("t2_grant_cyc_size", 128'(grant_cyc.size()), 128'd5);
    end
    wait_idle("t2_idle");

    // Backpressure: exactly FIFO_DEPTH issues, then one pop lets one more through
    rsp_ready = 1'b0; hs0 = hs_count; pops0 = pops;
    tick();
    for (int c = 0; c < 40; c++) begin
      rand_req(); req_valid = 2'b10;
      tick();
    end
    check_eq("t3_hs_full", 128'(hs_count - hs0), 128'(FIFO_DEPTH));
    check_eq("t3_stalled", 128'(req_ready), 128'd0);
    check_eq("t3_rsp_valid", 128'(rsp_valid), 128'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_pop_issue", 128'(req_ready), 128'd2);
    tick(); rsp_ready = 1'b0;
    repeat (5) begin rand_req(); tick(); end
    check_eq("t3_hs_after", 128'(hs_count - hs0), 128'(FIFO_DEPTH + 1));
    check_eq("t3_pops", 128'(pops - pops0), 128'd1);
    req_valid = 2'b00; rsp_ready = 1'b1;
    wait_idle("t3_idle");

    // Pop coinciding with a capture while the FIFO holds one entry
    rsp_ready = 1'b0;
    tick();
    rand_req(); req_valid = 2'b01; exp_a = req_state[127:0] ^ req_key[127:0];
    @(negedge clk);
    tick();
    rand_req(); exp_b = req_state[127:0] ^ req_key[127:0];
    @(negedge clk);
    tick(); req_valid = 2'b00;
    repeat (20) tick();
    @(negedge clk);
    check_eq("t4_not_yet", 128'(rsp_valid), 128'd0);
    tick(); rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_head_a_valid", 128'(rsp_valid), 128'd1);
    check_eq("t4_head_a", rsp_data, exp_a);
    tick(); rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("t4_head_b_valid", 128'(rsp_valid), 128'd1);
    check_eq("t4_head_b", rsp_data, exp_b);
    tick();
    @(negedge clk);
    check_eq("t4_count_one", 128'(rsp_valid), 128'd1);
    tick(); rsp_ready = 1'b1;
    @(negedge clk);
    tick(); rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("t4_empty", 128'(rsp_valid), 128'd0);
    rsp_ready = 1'b1;
    wait_idle("t4_idle");

    // Reset mid-flight discards three in-flight blocks
    rsp_ready = 1'b1; pops0 = pops;
    tick();
    for (int c = 0; c < 3; c++) begin
      rand_req(); req_valid = 2'b01;
      tick();
    end
    req_valid = 2'b00;
    tick();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check_eq("t5_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("t5_busy", 128'(busy), 128'd0);
    check_eq("t5_core_state", core_state, 128'd0);
    check_eq("t5_core_key", core_key, 128'd0);
    check_eq("t5_rsp_data", rsp_data, 128'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_eq("t5_no_rsp", 128'(seen), 128'd0);
    check_eq("t5_no_pops", 128'(pops - pops0), 128'd0);
    tick();
    rand_req(); req_valid = 2'b11;
    @(negedge clk);
    check_eq("t5_first_grant", 128'(req_ready), 128'd1);
    tick(); req_valid = 2'b00;
    wait_idle("t5_idle");
    check_eq("t5_post_pops", 128'(pops - pops0), 128'd1);

    // Fairness: requester 1 joins at cycle 10 while requester 0 stays valid
    rsp_ready = 1'b1; mark = 0;
    tick();
    for (int c = 0; c < 40; c++) begin
      if (c == 10) mark = grant_log.size();
      rand_req();
      req_valid = (c >= 10) ? 2'b11 : 2'b01;
      tick();
    end
    req_valid = 2'b00;
    opps = 99;
    for (int k = grant_log.size() - 1; k >= mark; k--)
      if (grant_log[k] == 1) opps = k - mark;
    check_eq("t6_fair_within2", 128'(opps < 2), 128'd1);
    wait_idle("t6_idle");

    check_eq("final_sb_empty", 128'(sb_data.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
